// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES stream feeder: the control state enum
// and the block/word geometry used by the feeder and its serializer.
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef enum logic [2:0] {
        NEED_KEY,
        KEY_INIT,
        KEY_WAIT,
        COLLECT,
        START,
        CORE_WAIT,
        DRAIN
    } feeder_state_t;

endpackage

// File: rtl/aes_word_serializer.sv
// Loads a 128-bit block and shifts it out MSW first as 32-bit valid/ready
// words. A word moves when tvalid and tready are both high at a rising edge.
module aes_word_serializer
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [AES_BLOCK_W-1:0] load_data,
    output logic [AES_WORD_W-1:0]  tdata,
    output logic                   tvalid,
    input  logic                   tready,
    output logic                   done
);

    logic [AES_BLOCK_W-1:0] buf_q, buf_d;
    logic                   valid_q, valid_d;
    logic [1:0]             cnt_q, cnt_d;

    always_comb begin
        buf_d   = buf_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (load) begin
            buf_d   = load_data;
            valid_d = 1'b1;
            cnt_d   = 2'd0;
        end else if (valid_q && tready) begin
            buf_d = {buf_q[AES_BLOCK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
            cnt_d = cnt_q + 2'd1;
            // done is combinational so the parent leaves DRAIN on the last edge
            if (cnt_q == 2'(AES_WORDS_PER_BLOCK - 1)) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            buf_q   <= buf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tdata  = buf_q[AES_BLOCK_W-1:AES_BLOCK_W-AES_WORD_W];
    assign tvalid = valid_q;

endmodule

// File: rtl/aes_enc_stream_feeder.sv
// Word-stream adapter for the AES encryption core: packs four input words,
// sequences key-init and next/ready, and serialises the result back out.
module aes_enc_stream_feeder
    import aes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [AES_BLOCK_W-1:0] cfg_key,
    input  logic                   cfg_key_load,
    input  logic [AES_WORD_W-1:0]  s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [AES_WORD_W-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [AES_BLOCK_W-1:0] core_key,
    output logic                   core_key_init,
    input  logic                   core_key_ready,
    output logic [AES_BLOCK_W-1:0] core_block,
    output logic                   core_next,
    input  logic [AES_BLOCK_W-1:0] core_result,
    input  logic                   core_block_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       blk_cnt
);

    feeder_state_t          state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic [AES_BLOCK_W-1:0] blk_q, blk_d;
    logic [AES_BLOCK_W-1:0] pend_key_q, pend_key_d;
    logic                   pend_q, pend_d;
    logic                   key_init_q, key_init_d;
    logic                   next_q, next_d;
    logic                   skip_q, skip_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       blk_cnt_q, blk_cnt_d;
    logic                   s_hs;
    logic                   load_taken;
    logic                   ser_load;
    logic                   ser_done;

    assign s_hs = s_tvalid && s_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        blk_d      = blk_q;
        pend_key_d = pend_key_q;
        pend_d     = pend_q;
        key_init_d = 1'b0;
        next_d     = 1'b0;
        skip_d     = 1'b0;
        blk_cnt_d  = blk_cnt_q;
        load_taken = 1'b0;
        ser_load   = 1'b0;

        case (state_q)
            NEED_KEY: begin
                if (cfg_key_load) begin
                    key_d      = cfg_key;
                    key_init_d = 1'b1;
                    load_taken = 1'b1;
                    state_d    = KEY_INIT;
                end
            end
            KEY_INIT: begin
                skip_d  = 1'b1;
                state_d = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (!skip_q && core_key_ready) state_d = COLLECT;
            end
            COLLECT: begin
                // A word accepted in the same cycle as a load wins; the load then waits for the next block
                if (cnt_q == 2'd0 && (cfg_key_load || pend_q) && !s_hs) begin
                    key_d      = cfg_key_load ? cfg_key : pend_key_q;
                    pend_d     = 1'b0;
                    key_init_d = 1'b1;
                    load_taken = 1'b1;
                    state_d    = KEY_INIT;
                end else if (s_hs) begin
                    blk_d = {blk_q[AES_BLOCK_W-AES_WORD_W-1:0], s_tdata};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(AES_WORDS_PER_BLOCK - 1)) begin
                        cnt_d   = 2'd0;
                        next_d  = 1'b1;
                        state_d = START;
                    end
                end
            end
            START: begin
                skip_d  = 1'b1;
                state_d = CORE_WAIT;
            end
            CORE_WAIT: begin
                if (!skip_q && core_block_ready) begin
                    ser_load = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (ser_done) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = COLLECT;
                end
            end
            default: state_d = NEED_KEY;
        endcase

        if (cfg_key_load && !load_taken) begin
            pend_d     = 1'b1;
            pend_key_d = cfg_key;
        end

        // Input is closed at a block boundary while a reload is waiting to be taken
        s_ready_d = (state_d == COLLECT) && !(pend_d && cnt_d == 2'd0);
        busy_d    = !((state_d == NEED_KEY) || (state_d == COLLECT && cnt_d == 2'd0));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= NEED_KEY;
            cnt_q      <= 2'd0;
            key_q      <= '0;
            blk_q      <= '0;
            pend_key_q <= '0;
            pend_q     <= 1'b0;
            key_init_q <= 1'b0;
            next_q     <= 1'b0;
            skip_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            blk_q      <= blk_d;
            pend_key_q <= pend_key_d;
            pend_q     <= pend_d;
            key_init_q <= key_init_d;
            next_q     <= next_d;
            skip_q     <= skip_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    aes_word_serializer u_ser (
        .clk       (aclk),
        .rst       (areset),
        .load      (ser_load),
        .load_data (core_result),
        .tdata     (m_tdata),
        .tvalid    (m_tvalid),
        .tready    (m_tready),
        .done      (ser_done)
    );

    assign s_tready      = s_ready_q;
    assign core_key      = key_q;
    assign core_key_init = key_init_q;
    assign core_block    = blk_q;
    assign core_next     = next_q;
    assign busy          = busy_q;
    assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_aes_enc_stream_feeder.sv
// Bench for aes_enc_stream_feeder: AES-128 core model, random word stimulus,
// and a scoreboard of expected keys, blocks and ciphertext words.
module tb_aes_enc_stream_feeder;

    localparam int CNT_W = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         aclk, areset;
    logic [127:0] cfg_key;
    logic         cfg_key_load;
    logic [31:0]  s_tdata;
    logic         s_tvalid, s_tready;
    logic [31:0]  m_tdata;
    logic         m_tvalid, m_tready;
    logic [127:0] core_key, core_block, core_result;
    logic         core_key_init, core_key_ready, core_next, core_block_ready;
    logic         busy;
    logic [CNT_W-1:0] blk_cnt;

    aes_enc_stream_feeder #(.CNT_W(CNT_W)) dut (
        .aclk(aclk), .areset(areset), .cfg_key(cfg_key), .cfg_key_load(cfg_key_load),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .core_key(core_key), .core_key_init(core_key_init), .core_key_ready(core_key_ready),
        .core_block(core_block), .core_next(core_next), .core_result(core_result),
        .core_block_ready(core_block_ready), .busy(busy), .blk_cnt(blk_cnt)
    );

    // ---------------- clock/reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    logic [31:0]  exp_q[$];
    logic [127:0] blk_exp_q[$];
    logic [127:0] key_exp_q[$];
    logic [127:0] cur_key;
    int           rdy_mode;
    logic [7:0]   sb[256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] a, p;
        for (int v = 0; v < 256; v++) begin
            a = 8'(v);
            p = 8'h01;
            for (int k = 0; k < 254; k++) p = gmul(p, a);
            sb[v] = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w[44];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [127:0] st;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[st[127-8*i -: 8]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    // ---------------- core model ----------------
    // The ready level in the cycle right after a pulse is a don't-care for the feeder, so it is randomised.
    initial begin
        logic [127:0] mkey, mblk;
        int kcnt, bcnt;
        bit kdrop, bdrop;
        kcnt = 0; bcnt = 0; kdrop = 0; bdrop = 0;
        mkey = '0; mblk = '0;
        core_key_ready = 1'b1; core_block_ready = 1'b1; core_result = '0;
        forever begin
            @(posedge aclk); #1;
            if (areset) begin
                kcnt = 0; bcnt = 0; kdrop = 0; bdrop = 0;
                core_key_ready = 1'b1; core_block_ready = 1'b1;
                continue;
            end
            if (kdrop) begin
                core_key_ready = 1'($urandom_range(0, 1)); kdrop = 0;
            end else if (kcnt > 0) begin
                core_key_ready = 1'b0;
                kcnt--;
                if (kcnt == 0) core_key_ready = 1'b1;
            end
            if (bdrop) begin
                core_block_ready = 1'($urandom_range(0, 1));
                core_result = {$urandom(), $urandom(), $urandom(), $urandom()};
                bdrop = 0;
            end else if (bcnt > 0) begin
                core_block_ready = 1'b0;
                bcnt--;
                if (bcnt == 0) begin
                    core_block_ready = 1'b1;
                    core_result = aes_enc(mkey, mblk);
                end
            end
            if (core_key_init) begin
                mkey = core_key; kdrop = 1; kcnt = $urandom_range(2, 6);
            end
            if (core_next) begin
                check("core_idle_at_next", {core_key_ready, core_block_ready, kdrop, bdrop}, 4'b1100);
                mblk = core_block; bdrop = 1; bcnt = $urandom_range(2, 7);
            end
        end
    end

    // ---------------- m_tready driver ----------------
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int out_words = 0;
    int blocks_done = 0;
    bit chk_cnt = 0;
    always @(negedge aclk) begin
        if (areset) begin
            out_words = 0; blocks_done = 0; chk_cnt = 0;
        end else begin
            if (chk_cnt) begin
                check("blk_cnt", blk_cnt, (blocks_done % (1 << CNT_W)));
                chk_cnt = 0;
            end
            check("s_tready_m_tvalid_overlap", s_tready && m_tvalid, 0);
            if (core_key_init) begin
                if (key_exp_q.size() == 0) fail_now("unexpected_core_key_init");
                else check("core_key", core_key, key_exp_q.pop_front());
            end
            if (core_next) begin
                if (blk_exp_q.size() == 0) fail_now("unexpected_core_next");
                else check("core_block", core_block, blk_exp_q.pop_front());
            end
            if (s_tvalid && s_tready) check("keys_pending_at_word_accept", key_exp_q.size(), 0);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) fail_now("unexpected_output_word");
                else check("m_tdata", m_tdata, exp_q.pop_front());
                out_words++;
                if (out_words % 4 == 0) begin
                    blocks_done++;
                    chk_cnt = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] w, input int max_gap);
        int n;
        bit hs;
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge aclk); #1;
        end
        s_tdata = w; s_tvalid = 1'b1;
        n = 0; hs = 0;
        while (!hs) begin
            @(negedge aclk);
            hs = s_tready;
            @(posedge aclk); #1;
            n++;
            if (!hs && n > 3000) begin
                fail_now("s_tready_timeout");
                break;
            end
        end
        s_tvalid = 1'b0; s_tdata = '0;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic [127:0] ct, input int max_gap);
        blk_exp_q.push_back(blk);
        for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
        for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], max_gap);
    endtask

    task automatic load_key(input logic [127:0] k);
        cfg_key = k; cfg_key_load = 1'b1;
        key_exp_q.push_back(k);
        cur_key = k;
        @(posedge aclk); #1;
        cfg_key_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || blk_exp_q.size() != 0 || key_exp_q.size() != 0) && n < 3000) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 3000) fail_now("scoreboard_drain_timeout");
        repeat (3) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_core_key_init"}, core_key_init, 0);
        check({tag, "_core_next"}, core_next, 0);
        check({tag, "_core_key"}, core_key, 0);
        check({tag, "_core_block"}, core_block, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_blk_cnt"}, blk_cnt, 0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #2;
        check_reset_outputs("reset");
        exp_q.delete(); blk_exp_q.delete(); key_exp_q.delete();
        repeat (3) begin
            @(posedge aclk); #1;
        end
        areset = 1'b0;
        @(posedge aclk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] b, k;
        int n;
        areset = 1'b1; cfg_key = '0; cfg_key_load = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; rdy_mode = 0; cur_key = '0;
        build_sbox();
        @(posedge aclk); #1;
        do_reset();

        // No key loaded: input stays closed
        s_tdata = 32'hdeadbeef; s_tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            check("s_tready_without_key", s_tready, 0);
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0;

        // Known-answer block, steady then throttled
        load_key(FIPS_KEY);
        send_block(FIPS_PT, FIPS_CT, 0);
        wait_idle();
        rdy_mode = 1;
        send_block(FIPS_PT, FIPS_CT, 3);
        wait_idle();

        // Key reload while the core is working on a block
        rdy_mode = 0;
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(b, aes_enc(cur_key, b), 0);
        n = 0;
        while (!core_next && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 50) fail_now("core_next_timeout");
        @(posedge aclk); #1;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_key(k);
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(b, aes_enc(k, b), 1);
        wait_idle();

        // Random blocks with random back-pressure and occasional reloads
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            send_block(b, aes_enc(cur_key, b), 2);
            if ($urandom_range(0, 2) == 0) load_key({$urandom(), $urandom(), $urandom(), $urandom()});
        end
        wait_idle();

        // Reset with two words held, then a fresh key and block
        rdy_mode = 0;
        send_word(32'h01234567, 0);
        send_word(32'h89abcdef, 0);
        do_reset();
        check_reset_outputs("post_reset");
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_key(k);
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(b, aes_enc(k, b), 1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
